// File: rtl/cmd_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the command dispatcher.
package cmd_pkg;

  localparam logic [7:0] OP_SET_BASE   = 8'h02;
  localparam logic [7:0] OP_CALIBRATE  = 8'h10;
  localparam logic [7:0] OP_EMER_LAND  = 8'h11;
  localparam logic [7:0] OP_MOTORS_OFF = 8'h12;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NAK  = 8'hEE;
  localparam logic [7:0] RESP_NONE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_RAMP   = 3'd2,
    ST_CAL    = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // True when op addresses one of the num_ch setpoint channels.
  function automatic logic is_set_op(input logic [7:0] op, input int num_ch);
    logic [8:0] lim;
    lim = 9'(OP_SET_BASE) + 9'(num_ch);
    return (op >= OP_SET_BASE) && ({1'b0, op} < lim);
  endfunction

endpackage

// File: rtl/sp_bank.sv
// Bank of NUM_CH setpoint registers with single-channel write and clear-all.
module sp_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     clr_all,
  output logic [NUM_CH*DATA_W-1:0] sp
);

  logic [DATA_W-1:0] bank_r [NUM_CH];

  // Setpoint storage: clear-all wins over a channel write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) bank_r[k] <= {DATA_W{1'b0}};
    end else if (clr_all) begin
      for (int k = 0; k < NUM_CH; k++) bank_r[k] <= {DATA_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (we && (idx == IDX_W'(k))) bank_r[k] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign sp[g*DATA_W +: DATA_W] = bank_r[g];
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes opcodes into setpoint writes, calibration
// sequencing, motor shutdown and a watchdog that lands the craft when idle.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int FAST_SIM  = 1,
  parameter int RAMP_BITS = 26,
  parameter int CAL_TMO   = 1 << 20,
  parameter int WDOG_CYC  = 1 << 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_rdy,
  input  logic [7:0]               cmd,
  input  logic [DATA_W-1:0]        data,
  input  logic                     cal_done,
  output logic                     clr_cmd_rdy,
  output logic [7:0]               resp,
  output logic                     send_resp,
  output logic [NUM_CH*DATA_W-1:0] sp,
  output logic                     strt_cal,
  output logic                     inertial_cal,
  output logic                     motors_off,
  output logic                     wdog_trip
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Terminal counts are "length minus one" because the timers start at zero.
  localparam logic [31:0] RAMP_LAST = (FAST_SIM != 0) ? 32'd511
                                                      : ((32'd1 << RAMP_BITS) - 32'd1);
  localparam logic [31:0] CAL_LAST  = 32'(CAL_TMO - 1);
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYC - 1);

  state_e state_r, state_nxt_s;
  logic [31:0] tmr_r;
  logic [31:0] wd_cnt_r;
  logic motors_off_r, inertial_cal_r, strt_cal_r, wdog_trip_r;
  logic send_resp_r, clr_cmd_rdy_r;
  logic [7:0] resp_r;

  logic [7:0]       resp_byte_s;
  logic             sp_we_s;
  logic [IDX_W-1:0] sp_idx_s;
  logic             emer_clr_s;
  logic             mo_set_s;
  logic             tmr_clr_s;
  logic             wd_clr_s;
  logic             strt_nxt_s;
  logic             wd_exp_s;

  // Next-state and per-state control decode.
  always_comb begin
    state_nxt_s = state_r;
    resp_byte_s = RESP_NONE;
    sp_we_s     = 1'b0;
    sp_idx_s    = {IDX_W{1'b0}};
    emer_clr_s  = 1'b0;
    mo_set_s    = 1'b0;
    tmr_clr_s   = 1'b0;
    wd_clr_s    = 1'b0;
    strt_nxt_s  = 1'b0;
    wd_exp_s    = (state_r == ST_IDLE) && !motors_off_r && (wd_cnt_r == WDOG_LAST);
    case (state_r)
      ST_IDLE: begin
        if (cmd_rdy) begin
          state_nxt_s = ST_DECODE;
          tmr_clr_s   = 1'b1;
          wd_clr_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (is_set_op(cmd, NUM_CH)) begin
          sp_we_s     = 1'b1;
          sp_idx_s    = IDX_W'(cmd - OP_SET_BASE);
          resp_byte_s = RESP_ACK;
          state_nxt_s = ST_RESP;
        end else if (cmd == OP_EMER_LAND) begin
          emer_clr_s  = 1'b1;
          resp_byte_s = RESP_ACK;
          state_nxt_s = ST_RESP;
        end else if (cmd == OP_MOTORS_OFF) begin
          mo_set_s    = 1'b1;
          resp_byte_s = RESP_ACK;
          state_nxt_s = ST_RESP;
        end else if (cmd == OP_CALIBRATE) begin
          tmr_clr_s   = 1'b1;
          state_nxt_s = ST_RAMP;
        end else begin
          resp_byte_s = RESP_NAK;
          state_nxt_s = ST_RESP;
        end
      end
      ST_RAMP: begin
        if (tmr_r == RAMP_LAST) begin
          strt_nxt_s  = 1'b1;
          tmr_clr_s   = 1'b1;
          state_nxt_s = ST_CAL;
        end else begin
          state_nxt_s = ST_RAMP;
        end
      end
      ST_CAL: begin
        // cal_done is checked first so it wins a tie with the timeout.
        if (cal_done) begin
          resp_byte_s = RESP_ACK;
          state_nxt_s = ST_RESP;
        end else if (tmr_r == CAL_LAST) begin
          resp_byte_s = RESP_NAK;
          mo_set_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_CAL;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Shared ramp/calibration timer, running only in RAMP and CAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          tmr_r <= 32'd0;
    else if (tmr_clr_s)                                  tmr_r <= 32'd0;
    else if ((state_r == ST_RAMP) || (state_r == ST_CAL)) tmr_r <= tmr_r + 32'd1;
  end

  // Idle watchdog: counts IDLE cycles with motors running, restarts on expiry or command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       wd_cnt_r <= 32'd0;
    else if (wd_clr_s || wd_exp_s)                    wd_cnt_r <= 32'd0;
    else if ((state_r == ST_IDLE) && !motors_off_r)   wd_cnt_r <= wd_cnt_r + 32'd1;
  end

  // Motors-off flag: set wins over the clear caused by an active calibration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              motors_off_r <= 1'b1;
    else if (mo_set_s)       motors_off_r <= 1'b1;
    else if (inertial_cal_r) motors_off_r <= 1'b0;
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inertial_cal_r <= 1'b0;
      strt_cal_r     <= 1'b0;
      wdog_trip_r    <= 1'b0;
      send_resp_r    <= 1'b0;
      clr_cmd_rdy_r  <= 1'b0;
      resp_r         <= RESP_NONE;
    end else begin
      inertial_cal_r <= (state_nxt_s == ST_RAMP) || (state_nxt_s == ST_CAL);
      strt_cal_r     <= strt_nxt_s;
      wdog_trip_r    <= wd_exp_s;
      send_resp_r    <= (state_nxt_s == ST_RESP);
      clr_cmd_rdy_r  <= (state_nxt_s == ST_RESP);
      resp_r         <= (state_nxt_s == ST_RESP) ? resp_byte_s : RESP_NONE;
    end
  end

  sp_bank #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_sp_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (sp_we_s),
    .idx     (sp_idx_s),
    .wdata   (data),
    .clr_all (emer_clr_s | wd_exp_s),
    .sp      (sp)
  );

  assign clr_cmd_rdy  = clr_cmd_rdy_r;
  assign resp         = resp_r;
  assign send_resp    = send_resp_r;
  assign strt_cal     = strt_cal_r;
  assign inertial_cal = inertial_cal_r;
  assign motors_off   = motors_off_r;
  assign wdog_trip    = wdog_trip_r;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: vector table of single commands,
// a response scoreboard, and hand-written calibration/watchdog/reset sequences.
module tb_cmd_dispatch;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 16;
  localparam int CAL_TMO  = 64;
  localparam int WDOG_CYC = 200;

  logic clk = 1'b0;
  logic rst_n, cmd_rdy, cal_done;
  logic [7:0] cmd;
  logic [DATA_W-1:0] data;
  logic clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, wdog_trip;
  logic [7:0] resp;
  logic [NUM_CH*DATA_W-1:0] sp;

  int n_pass = 0;
  int n_total = 0;
  int trip_cnt = 0;
  int strt_cnt = 0;
  int resp_cnt = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  exp_resp;
    logic [63:0] exp_sp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  cmd_dispatch #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .FAST_SIM  (1),
    .RAMP_BITS (26),
    .CAL_TMO   (CAL_TMO),
    .WDOG_CYC  (WDOG_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_rdy      (cmd_rdy),
    .cmd          (cmd),
    .data         (data),
    .cal_done     (cal_done),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .resp         (resp),
    .send_resp    (send_resp),
    .sp           (sp),
    .strt_cal     (strt_cal),
    .inertial_cal (inertial_cal),
    .motors_off   (motors_off),
    .wdog_trip    (wdog_trip)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance to the next falling edge and run the output monitors/scoreboard.
  task automatic tick();
    logic [7:0] exp_b;
    @(negedge clk);
    if (send_resp === 1'b1) begin
      resp_cnt++;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: got resp %0h with no response expected", resp);
      end else begin
        exp_b = sb_q.pop_front();
        check("resp_byte", {56'd0, resp}, {56'd0, exp_b});
      end
    end
    if (wdog_trip === 1'b1) trip_cnt++;
    if (strt_cal === 1'b1) strt_cnt++;
  endtask

  // One non-calibrate command: latency, strobes and setpoints afterwards.
  task automatic do_cmd(input logic [7:0] c, input logic [15:0] d,
                        input logic [7:0] e, input logic [63:0] esp);
    tick();
    cmd_rdy = 1'b1; cmd = c; data = d;
    sb_q.push_back(e);
    tick();
    check("lat_n1_send", {63'd0, send_resp}, 64'd0);
    check("lat_n1_resp", {56'd0, resp}, 64'd0);
    tick();
    check("lat_n2_send", {63'd0, send_resp}, 64'd1);
    check("lat_n2_clr", {63'd0, clr_cmd_rdy}, 64'd1);
    cmd_rdy = 1'b0;
    tick();
    check("sp_after", sp, esp);
  endtask

  initial begin
    int k;
    int t0;
    int r0;

    vecs[0] = '{8'h03, 16'h1234, 8'hA5, 64'h0000_0000_1234_0000};
    vecs[1] = '{8'h02, 16'h00AA, 8'hA5, 64'h0000_0000_1234_00AA};
    vecs[2] = '{8'h05, 16'hBEEF, 8'hA5, 64'hBEEF_0000_1234_00AA};
    vecs[3] = '{8'h06, 16'hFFFF, 8'hEE, 64'hBEEF_0000_1234_00AA};
    vecs[4] = '{8'h00, 16'h5555, 8'hEE, 64'hBEEF_0000_1234_00AA};
    vecs[5] = '{8'h04, 16'h0F0F, 8'hA5, 64'hBEEF_0F0F_1234_00AA};
    vecs[6] = '{8'h12, 16'h9999, 8'hA5, 64'hBEEF_0F0F_1234_00AA};
    vecs[7] = '{8'h13, 16'h8888, 8'hEE, 64'hBEEF_0F0F_1234_00AA};
    vecs[8] = '{8'h01, 16'h7777, 8'hEE, 64'hBEEF_0F0F_1234_00AA};
    vecs[9] = '{8'hFF, 16'h6666, 8'hEE, 64'hBEEF_0F0F_1234_00AA};

    rst_n = 1'b0; cmd_rdy = 1'b0; cal_done = 1'b0; cmd = 8'h00; data = 16'h0000;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_outs",
          {56'd0, 1'b0, clr_cmd_rdy, send_resp, strt_cal, inertial_cal, wdog_trip, motors_off, 1'b0},
          {56'd0, 8'b0000_0010});
    check("reset_resp", {56'd0, resp}, 64'd0);
    check("reset_sp", sp, 64'd0);

    // Single-command vectors with motors off (watchdog idle).
    for (int i = 0; i < 10; i++) begin
      do_cmd(vecs[i].cmd, vecs[i].data, vecs[i].exp_resp, vecs[i].exp_sp);
      check("mo_hold", {63'd0, motors_off}, 64'd1);
    end

    // Calibration completed by cal_done.
    tick();
    cmd_rdy = 1'b1; cmd = 8'h10; data = 16'h0000;
    sb_q.push_back(8'hA5);
    tick();
    check("cal_ic_decode", {63'd0, inertial_cal}, 64'd0);
    tick();
    check("cal_ic_ramp", {63'd0, inertial_cal}, 64'd1);
    t0 = strt_cnt;
    k = 0;
    while (strt_cal !== 1'b1 && k < 2000) begin tick(); k++; end
    check("strt_delay", 64'(k), 64'd512);
    check("cal_ic_strt", {63'd0, inertial_cal}, 64'd1);
    repeat (3) tick();
    check("strt_single", 64'(strt_cnt - t0), 64'd1);
    check("strt_low", {63'd0, strt_cal}, 64'd0);
    check("motors_on_cal", {63'd0, motors_off}, 64'd0);
    cal_done = 1'b1;
    tick();
    check("cal_ack_send", {63'd0, send_resp}, 64'd1);
    cmd_rdy = 1'b0; cal_done = 1'b0;
    tick();
    check("cal_mo_after", {63'd0, motors_off}, 64'd0);
    check("cal_ic_after", {63'd0, inertial_cal}, 64'd0);

    // Watchdog: motors on, channels nonzero, no commands.
    do_cmd(8'h03, 16'h5A5A, 8'hA5, 64'hBEEF_0F0F_5A5A_00AA);
    t0 = trip_cnt;
    k = 0;
    while (wdog_trip !== 1'b1 && k < 1000) begin tick(); k++; end
    check("wdog_delay", 64'(k), 64'(WDOG_CYC));
    check("wdog_sp", sp, 64'd0);
    tick();
    check("wdog_pulse", {63'd0, wdog_trip}, 64'd0);
    repeat (150) tick();
    check("wdog_single", 64'(trip_cnt - t0), 64'd1);
    check("wdog_mo", {63'd0, motors_off}, 64'd0);

    // Emergency landing after setting channels.
    do_cmd(8'h02, 16'h1111, 8'hA5, 64'h0000_0000_0000_1111);
    do_cmd(8'h05, 16'h3333, 8'hA5, 64'h3333_0000_0000_1111);
    do_cmd(8'h11, 16'hABCD, 8'hA5, 64'h0000_0000_0000_0000);

    // Watchdog expiry in the same IDLE cycle as an incoming command.
    do_cmd(8'h02, 16'hAAAA, 8'hA5, 64'h0000_0000_0000_AAAA);
    repeat (WDOG_CYC - 2) tick();
    t0 = trip_cnt;
    do_cmd(8'h04, 16'h7777, 8'hA5, 64'h0000_7777_0000_0000);
    check("coinc_trip", 64'(trip_cnt - t0), 64'd1);

    // Calibration that times out.
    tick();
    cmd_rdy = 1'b1; cmd = 8'h10; data = 16'h0000;
    sb_q.push_back(8'hEE);
    k = 0;
    while (strt_cal !== 1'b1 && k < 2000) begin tick(); k++; end
    check("tmo_strt", {63'd0, strt_cal}, 64'd1);
    k = 0;
    while (send_resp !== 1'b1 && k < 500) begin tick(); k++; end
    check("tmo_len", 64'(k), 64'(CAL_TMO));
    check("tmo_mo", {63'd0, motors_off}, 64'd1);
    cmd_rdy = 1'b0;
    tick();
    check("tmo_ic", {63'd0, inertial_cal}, 64'd0);

    // Reset asserted mid-RAMP aborts without any response.
    tick();
    cmd_rdy = 1'b1; cmd = 8'h10;
    repeat (100) tick();
    check("rst_ic_ramp", {63'd0, inertial_cal}, 64'd1);
    check("rst_mo_ramp", {63'd0, motors_off}, 64'd0);
    cmd_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ic", {63'd0, inertial_cal}, 64'd0);
    check("rst_async_mo", {63'd0, motors_off}, 64'd1);
    check("rst_async_sp", sp, 64'd0);
    r0 = resp_cnt;
    t0 = strt_cnt;
    tick();
    rst_n = 1'b1;
    repeat (600) tick();
    check("rst_no_resp", 64'(resp_cnt - r0), 64'd0);
    check("rst_no_strt", 64'(strt_cnt - t0), 64'd0);

    do_cmd(8'h03, 16'h1234, 8'hA5, 64'h0000_0000_1234_0000);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of setpoint channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the setpoint/data width.
REQ-003 SHALL have parameter FAST_SIM, default 1, meaning a motor ramp of 2^9 cycles when 1 and 2^RAMP_BITS cycles when 0.
REQ-004 SHALL have parameter RAMP_BITS, default 26, meaning the full-speed ramp timer width.
REQ-005 SHALL have parameter CAL_TMO, default 2^20, meaning the maximum number of cycles spent in CAL before NAK.
REQ-006 SHALL have parameter WDOG_CYC, default 2^22, meaning the number of idle cycles (no accepted command, motors on) before watchdog landing.
REQ-007 SHALL have ports: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: cmd_rdy in 1, command valid; cmd in 8, opcode; data in DATA_W, payload; cal_done in 1, calibration complete.
REQ-009 SHALL have ports: clr_cmd_rdy out 1, consume pulse; resp out 8, response byte; send_resp out 1, response strobe.
REQ-010 SHALL have ports: sp out NUM_CH*DATA_W, setpoint channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have ports: strt_cal out 1; inertial_cal out 1; motors_off out 1; wdog_trip out 1, one-cycle watchdog pulse.

Function
REQ-012 SHALL use opcodes: SET_CH(k) = 0x02+k for k<NUM_CH; CALIBRATE 0x10; EMER_LAND 0x11; MOTORS_OFF 0x12; all others invalid.
REQ-013 SHALL implement FSM states IDLE, DECODE, RAMP, CAL, RESP; reset state IDLE.
REQ-014 IDLE: when cmd_rdy=1, SHALL go to DECODE and clear the shared timer and watchdog counter.
REQ-015 DECODE SET_CH(k): SHALL load channel k with data at the DECODE clock edge, then go to RESP with ACK 0xA5.
REQ-016 DECODE EMER_LAND: SHALL zero all channels, then go to RESP with ACK.
REQ-017 DECODE MOTORS_OFF: SHALL set motors_off, then go to RESP with ACK.
REQ-018 DECODE invalid opcode: SHALL go to RESP with NAK 0xEE and change no register.
REQ-019 DECODE CALIBRATE: SHALL go to RAMP.
REQ-020 RAMP: SHALL hold inertial_cal=1; at the terminal ramp count SHALL pulse strt_cal for one cycle, clear the timer and go to CAL.
REQ-021 CAL: SHALL hold inertial_cal=1; cal_done SHALL cause ACK; a timer count of CAL_TMO-1 without cal_done SHALL cause NAK, set motors_off and go to RESP; cal_done SHALL win if both occur in the same cycle.
REQ-022 RESP: for exactly one cycle SHALL drive send_resp=1, clr_cmd_rdy=1 and resp = the latched byte, then go to IDLE; resp SHALL be 0x00 outside RESP.
REQ-023 Latency: a non-calibrate command with cmd_rdy sampled at edge N SHALL produce send_resp high in cycle N+2.
REQ-024 motors_off: SHALL be cleared on the first cycle inertial_cal=1; set has priority over clear.
REQ-025 Watchdog: SHALL count only when motors_off=0 and the state is IDLE; at WDOG_CYC SHALL zero all channels, pulse wdog_trip and restart the count.
REQ-026 If a watchdog expiry coincides with a cmd_rdy in IDLE, the watchdog zeroing SHALL occur and the command SHALL still be processed normally.
REQ-027 SHALL ignore cmd_rdy outside IDLE; cmd and data SHALL be sampled only in DECODE.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE, sp all zero, motors_off=1, timers zero; all other outputs 0.
REQ-029 Reset asserted in RAMP or CAL SHALL abort the calibration with no response.

Structure
REQ-030 The opcode constants, the ACK/NAK bytes and the state enum SHALL reside in package cmd_pkg.
REQ-031 The setpoint bank SHALL be a sub-module sp_bank (NUM_CH, DATA_W) with write enable, index, data and clear-all inputs.

Verification
REQ-032 The bench SHALL cover: cmd 0x03, data 0x1234 -> channel 1 = 0x1234, resp 0xA5 at N+2, other channels unchanged.
REQ-033 The bench SHALL cover: cmd 0x02+NUM_CH (out of range) -> resp 0xEE, sp unchanged.
REQ-034 The bench SHALL cover: CALIBRATE with FAST_SIM=1 -> inertial_cal high, strt_cal pulse 512 cycles later, cal_done -> 0xA5, motors_off=0.
REQ-035 The bench SHALL cover: CALIBRATE without cal_done -> 0xEE after CAL_TMO cycles in CAL, motors_off=1.
REQ-036 The bench SHALL cover: motors on, channels nonzero, no command for WDOG_CYC -> all sp=0, a single wdog_trip pulse.
REQ-037 The bench SHALL cover: EMER_LAND after the channels are set -> all sp=0, resp 0xA5; rst_n pulsed mid-RAMP -> IDLE, no send_resp.
